mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit between the EX/MEM pipeline register and the MEM/WB register.
//  Drives a req/gnt/rvalid data-memory port and generates byte enables and store-data lane shifts.
//  Sign/zero-extends load data into mem_data_o, which feeds mem_i of the MEM/WB register.
//  Holds the pipeline (stall_o) while a bus transaction is outstanding.
// PARAMETERS
//  TIMEOUT_CYCLES  64  cycles in REQ+WAIT_R before the op is abandoned with bus_err_o
// PORTS
//  clk            in   1   pipeline clock; all state updates on rising edge
//  reset          in   1   synchronous, active-high reset
//  mem_rd_i       in   1   EX/MEM: instruction is a load
//  mem_wr_i       in   1   EX/MEM: instruction is a store (never set together with mem_rd_i)
//  kill_i         in   1   squash: suppresses launch of the op presented this cycle
//  funct3_i       in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  alu_out_i      in   32  effective byte address
//  rs2_data_i     in   32  store data, right-aligned
//  dmem_req_o     out  1   bus request
//  dmem_we_o      out  1   1 = write
//  dmem_addr_o    out  32  word address {addr[31:2],2'b00}
//  dmem_be_o      out  4   byte enables
//  dmem_wdata_o   out  32  lane-shifted store data
//  dmem_gnt_i     in   1   request accepted this cycle
//  dmem_rvalid_i  in   1   read data valid, >=1 cycle after gnt
//  dmem_rdata_i   in   32  read word
//  mem_data_o     out  32  extended load result, to MEM/WB mem_i
//  stall_o        out  1   freeze PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB
//  misalign_o     out  1   1-cycle pulse: misaligned access, op dropped
//  bus_err_o      out  1   1-cycle pulse: timeout, op dropped
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; timeout counter 0.
//  - op = (mem_rd_i|mem_wr_i) & ~kill_i.
//  - Misaligned means H with addr[0]=1, or W with addr[1:0]!=0.
//  - IDLE: op & misaligned -> misalign_o=1 for the cycle; no request, no stall; stay IDLE.
//  - IDLE: op & aligned -> stall_o=1 (combinational, same cycle); latch addr, we, be, wdata, funct3, addr[1:0]; go REQ.
//  - REQ: dmem_req_o=1 with latched fields stable until gnt; stall_o=1.
//    gnt & store -> DONE. gnt & load -> WAIT_R.
//  - WAIT_R: req=0, stall_o=1. On rvalid: mem_data_o <= extended lane data; go DONE. rvalid outside WAIT_R is ignored.
//  - DONE: stall_o=0 for exactly one cycle, so the op advances into MEM/WB; mem_data_o valid. No launch in DONE even if op is set; then go IDLE.
//  - mem_data_o holds its value until the next load completes. Stores leave it unchanged.
//  - Byte enables:
//    B: be = 4'b0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
//    H: be = 4'b0011 << addr[1:0]; wdata = {2{rs2[15:0]}}.
//    W: be = 4'b1111; wdata = rs2.
//  - Load extend: select byte/half by the latched addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
//  - Timeout: counter clears on entry to REQ and increments each cycle in REQ/WAIT_R.
//    When the count reaches TIMEOUT_CYCLES-1 with no gnt/rvalid: bus_err_o=1, mem_data_o <= 0, go DONE.
//  - Simultaneous gnt and rvalid in REQ is illegal on the bus; the bench must not drive it.
//  - reset asserted in any state -> IDLE next edge; req drops; no pulse outputs.
//  - Non-memory instructions (op=0): stall_o=0, outputs idle, zero added latency.
//  - Latency: store = 1 + gnt wait + 1 (DONE); load adds rvalid wait.
// TESTING
//  - LW addr 0x100, gnt on the first REQ cycle, rvalid 2 cycles later with 0xDEADBEEF
//    -> stall_o high 4 cycles, then DONE with mem_data_o=0xDEADBEEF.
//  - LB addr 0x103, rdata 0x80FF_FF7F -> be=4'b1000, mem_data_o=0xFFFFFF80; LBU same -> 0x00000080.
//  - SH addr 0x102, rs2=0x1234ABCD, gnt delayed 3 cycles
//    -> req/addr/be=4'b1100/wdata=0xABCDABCD stable until gnt; then DONE.
//  - LW addr 0x101 -> misalign_o 1 cycle, no dmem_req_o, stall_o=0.
//  - TIMEOUT_CYCLES=8, gnt never asserted
//    -> bus_err_o pulses after 8 REQ cycles; DONE with mem_data_o=0; back to IDLE.
//  - reset mid-WAIT_R -> next cycle IDLE, stall_o=0, dmem_req_o=0.
//    A late rvalid is ignored; mem_data_o=0.

Source files
------------

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Brief    : MEM-stage load/store unit: req/gnt/rvalid data port, byte lanes,
//            load extension and pipeline stall while a bus op is outstanding.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic        kill_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] rs2_data_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] mem_data_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_err_q, bus_err_d;

  logic              op;
  logic              misaligned;
  logic [3:0]        launch_be;
  logic [31:0]       launch_wdata;
  logic [31:0]       rdata_shifted;
  logic [31:0]       load_ext;

  // Reset suppresses launch so no stall or misalign pulse escapes during reset.
  assign op         = (mem_rd_i | mem_wr_i) & ~kill_i & ~reset;
  assign misaligned = ((funct3_i[1:0] == 2'b01) & alu_out_i[0]) |
                      ((funct3_i[1:0] == 2'b10) & (alu_out_i[1:0] != 2'b00));

  always_comb begin
    launch_be    = 4'b1111;
    launch_wdata = rs2_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        launch_be    = 4'b0001 << alu_out_i[1:0];
        launch_wdata = {4{rs2_data_i[7:0]}};
      end
      2'b01: begin
        launch_be    = 4'b0011 << alu_out_i[1:0];
        launch_wdata = {2{rs2_data_i[15:0]}};
      end
      default: begin
        launch_be    = 4'b1111;
        launch_wdata = rs2_data_i;
      end
    endcase
  end

  assign rdata_shifted = dmem_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = dmem_rdata_i;
    case (funct3_q)
      3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b100:  load_ext = {24'd0, rdata_shifted[7:0]};
      3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b101:  load_ext = {16'd0, rdata_shifted[15:0]};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    mem_data_d = mem_data_q;
    cnt_d      = cnt_q;
    bus_err_d  = 1'b0;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    dmem_req_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op) begin
          if (misaligned) begin
            misalign_o = 1'b1;
          end else begin
            stall_o  = 1'b1;
            addr_d   = alu_out_i;
            we_d     = mem_wr_i;
            be_d     = launch_be;
            wdata_d  = launch_wdata;
            funct3_d = funct3_i;
            cnt_d    = '0;
            state_d  = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall_o    = 1'b1;
        dmem_req_o = 1'b1;
        cnt_d      = cnt_q + CNT_ONE;
        if (dmem_gnt_i) begin
          state_d = we_q ? ST_DONE : ST_WAIT_R;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_d  = 1'b1;
          mem_data_d = '0;
          state_d    = ST_DONE;
        end
      end
      ST_WAIT_R: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + CNT_ONE;
        if (dmem_rvalid_i) begin
          mem_data_d = load_ext;
          state_d    = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_d  = 1'b1;
          mem_data_d = '0;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        // One unstalled cycle lets the finished op advance; never relaunch here.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      mem_data_q <= '0;
      cnt_q      <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      mem_data_q <= mem_data_d;
      cnt_q      <= cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign dmem_we_o    = dmem_req_o & we_q;
  assign dmem_addr_o  = dmem_req_o ? {addr_q[31:2], 2'b00} : 32'd0;
  assign dmem_be_o    = dmem_req_o ? be_q : 4'd0;
  assign dmem_wdata_o = dmem_req_o ? wdata_q : 32'd0;
  assign mem_data_o   = mem_data_q;
  assign bus_err_o    = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_lsu
// Brief    : Self-checking bench for mem_stage_lsu with a reactive bus model
//            and an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd_i, mem_wr_i, kill_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_out_i, rs2_data_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] mem_data_o;
  logic        stall_o, misalign_o, bus_err_o;

  mem_stage_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .kill_i(kill_i),
    .funct3_i(funct3_i), .alu_out_i(alu_out_i), .rs2_data_i(rs2_data_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .mem_data_o(mem_data_o), .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic        err;
    int          stall;
    int          reqs;
  } exp_t;

  exp_t sb[$];

  int          obs_stall, obs_reqs;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata, obs_addr, obs_data;
  logic        obs_we, obs_err, obs_mis, obs_unstable, obs_hung, obs_err_early;
  logic [31:0] last_data;

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    if (f3[1:0] == 2'b00) begin
      case (a[1:0])
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (f3[1:0] == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (f3[1:0] == 2'b01) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    b = r[{a[1:0], 3'b000} +: 8];
    h = a[1] ? r[31:16] : r[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return r;
    endcase
  endfunction

  function automatic exp_t mk_exp(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] rs2, input logic [31:0] data,
                                  input int gdly, input int rdly, input logic err);
    exp_t e;
    e.data  = data;
    e.addr  = {a[31:2], 2'b00};
    e.be    = m_be(f3, a);
    e.wdata = m_wd(f3, rs2);
    e.we    = wr;
    e.err   = err;
    e.reqs  = gdly + 1;
    e.stall = wr ? (gdly + 2) : (gdly + 2 + rdly);
    return e;
  endfunction

  // Drives one op and acts as the bus slave; records what the DUT did.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2,
                       input int gdly, input int rdly, input logic [31:0] rdata,
                       input bit never_gnt);
    bit granted, done;
    int after;
    obs_stall = 0; obs_reqs = 0; obs_unstable = 0; obs_hung = 0;
    obs_err_early = 0; obs_err = 0; obs_mis = 0;
    granted = 0; done = 0; after = 0;
    @(posedge clk); #1;
    mem_rd_i = rd; mem_wr_i = wr; kill_i = 0; funct3_i = f3;
    alu_out_i = addr; rs2_data_i = rs2;
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 32'h0;
    @(negedge clk);
    obs_mis  = misalign_o;
    obs_data = mem_data_o;
    if (dmem_req_o) obs_unstable = 1;
    if (!stall_o) return;
    obs_stall = 1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk); #1;
      dmem_gnt_i = 0; dmem_rvalid_i = 0;
      if (dmem_req_o) begin
        if (obs_reqs == 0) begin
          obs_be = dmem_be_o; obs_wdata = dmem_wdata_o; obs_addr = dmem_addr_o; obs_we = dmem_we_o;
        end else if ({dmem_be_o, dmem_wdata_o, dmem_addr_o, dmem_we_o} !== {obs_be, obs_wdata, obs_addr, obs_we}) begin
          obs_unstable = 1;
        end
        if (!never_gnt && obs_reqs == gdly) begin
          dmem_gnt_i = 1; granted = 1;
        end
        obs_reqs++;
      end else if (granted) begin
        after++;
        if (after == rdly) begin
          dmem_rvalid_i = 1; dmem_rdata_i = rdata;
        end
      end
      @(negedge clk);
      if (stall_o) begin
        obs_stall++;
        if (bus_err_o) obs_err_early = 1;
      end else begin
        done = 1; obs_data = mem_data_o; obs_err = bus_err_o;
      end
    end
    obs_hung = !done;
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    mem_rd_i = 0; mem_wr_i = 0; kill_i = 0; funct3_i = 0; alu_out_i = 0; rs2_data_i = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    mem_rd_i = 1; funct3_i = 3'b010; alu_out_i = 32'h101;
    @(negedge clk);
    checks++;
    if ({misalign_o, stall_o} !== 2'b00) begin errors++; $display("FAIL reset_misalign_gate: got %b expected 00", {misalign_o, stall_o}); end
    @(posedge clk); #1;
    alu_out_i = 32'h100;
    @(negedge clk);
    checks++;
    if ({stall_o, dmem_req_o} !== 2'b00) begin errors++; $display("FAIL reset_stall_gate: got %b expected 00", {stall_o, dmem_req_o}); end
    @(posedge clk); #1;
    reset = 0; mem_rd_i = 0; alu_out_i = 0; funct3_i = 0;
    @(negedge clk);
    checks++;
    if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, mem_data_o, stall_o, misalign_o, bus_err_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero req=%b addr=%h be=%b wd=%h data=%h stall=%b expected all 0",
                         dmem_req_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, mem_data_o, stall_o);
    end
  endtask

  task automatic test_lw();
    exp_t e;
    sb.push_back(mk_exp(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 1'b0));
    do_op(1, 0, 3'b010, 32'h100, 32'h0, 0, 2, 32'hDEADBEEF, 0);
    e = sb.pop_front();
    checks++; if (obs_hung) begin errors++; $display("FAIL lw_hung: no DONE within bound"); end
    checks++; if (obs_stall !== e.stall) begin errors++; $display("FAIL lw_stall_cycles: got %0d expected %0d", obs_stall, e.stall); end
    checks++; if (obs_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", obs_data); end
    checks++; if ({obs_addr, obs_be, obs_we} !== {e.addr, e.be, e.we}) begin errors++; $display("FAIL lw_bus: got addr=%h be=%b we=%b expected addr=%h be=%b we=%b", obs_addr, obs_be, obs_we, e.addr, e.be, e.we); end
    checks++; if (obs_reqs !== e.reqs) begin errors++; $display("FAIL lw_req_cycles: got %0d expected %0d", obs_reqs, e.reqs); end
  endtask

  task automatic test_lb_lbu();
    logic [2:0]  f3s [2] = '{3'b000, 3'b100};
    logic [31:0] res [2] = '{32'hFFFFFF80, 32'h00000080};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk_exp(1'b0, f3s[i], 32'h103, 32'h0, res[i], 1, 1, 1'b0));
      do_op(1, 0, f3s[i], 32'h103, 32'h0, 1, 1, 32'h80FFFF7F, 0);
      e = sb.pop_front();
      checks++; if (obs_be !== 4'b1000) begin errors++; $display("FAIL lb_be[%0d]: got %b expected 1000", i, obs_be); end
      checks++; if (obs_data !== e.data) begin errors++; $display("FAIL lb_data[%0d]: got %h expected %h", i, obs_data, e.data); end
      checks++; if (obs_stall !== e.stall) begin errors++; $display("FAIL lb_stall[%0d]: got %0d expected %0d", i, obs_stall, e.stall); end
    end
  endtask

  task automatic test_sh();
    exp_t e;
    sb.push_back(mk_exp(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h00000080, 3, 0, 1'b0));
    do_op(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 3, 0, 32'h0, 0);
    e = sb.pop_front();
    checks++; if ({obs_be, obs_wdata, obs_addr, obs_we} !== {4'b1100, 32'hABCDABCD, 32'h100, 1'b1}) begin
      errors++; $display("FAIL sh_bus: got be=%b wd=%h addr=%h we=%b expected be=1100 wd=abcdabcd addr=00000100 we=1", obs_be, obs_wdata, obs_addr, obs_we);
    end
    checks++; if (obs_unstable) begin errors++; $display("FAIL sh_stable: got fields changing before gnt expected stable"); end
    checks++; if (obs_reqs !== 4) begin errors++; $display("FAIL sh_req_cycles: got %0d expected 4", obs_reqs); end
    checks++; if (obs_stall !== e.stall) begin errors++; $display("FAIL sh_stall: got %0d expected %0d", obs_stall, e.stall); end
    checks++; if (obs_data !== e.data) begin errors++; $display("FAIL sh_data_kept: got %h expected %h", obs_data, e.data); end
  endtask

  task automatic test_misalign();
    do_op(1, 0, 3'b010, 32'h101, 32'h0, 0, 1, 32'h0, 0);
    checks++; if ({obs_mis, obs_stall != 0, obs_unstable} !== 3'b100) begin
      errors++; $display("FAIL lw_misalign: got mis=%b stall=%0d req=%b expected mis=1 stall=0 req=0", obs_mis, obs_stall, obs_unstable);
    end
    go_idle();
    checks++; if ({misalign_o, dmem_req_o, stall_o} !== 3'b000) begin errors++; $display("FAIL misalign_pulse: got %b expected 000", {misalign_o, dmem_req_o, stall_o}); end
    do_op(1, 0, 3'b001, 32'h103, 32'h0, 0, 1, 32'h0, 0);
    checks++; if ({obs_mis, obs_stall != 0} !== 2'b10) begin errors++; $display("FAIL lh_misalign: got mis=%b stall=%0d expected mis=1 stall=0", obs_mis, obs_stall); end
    do_op(1, 0, 3'b001, 32'h102, 32'h0, 0, 1, 32'h80011234, 0);
    checks++; if ({obs_mis, obs_data} !== {1'b0, 32'hFFFF8001}) begin errors++; $display("FAIL lh_aligned: got mis=%b data=%h expected mis=0 data=ffff8001", obs_mis, obs_data); end
    last_data = 32'hFFFF8001;
  endtask

  task automatic test_kill_nonmem();
    @(posedge clk); #1;
    mem_rd_i = 1; kill_i = 1; funct3_i = 3'b010; alu_out_i = 32'h101;
    dmem_gnt_i = 0; dmem_rvalid_i = 0;
    @(negedge clk);
    checks++; if ({stall_o, misalign_o} !== 2'b00) begin errors++; $display("FAIL kill_comb: got %b expected 00", {stall_o, misalign_o}); end
    @(posedge clk); #1;
    alu_out_i = 32'h100;
    @(negedge clk);
    @(posedge clk); #1;
    mem_rd_i = 0; kill_i = 0;
    @(negedge clk);
    checks++; if ({dmem_req_o, stall_o} !== 2'b00) begin errors++; $display("FAIL kill_no_launch: got %b expected 00", {dmem_req_o, stall_o}); end
    do_op(0, 0, 3'b010, 32'h200, 32'h5, 0, 1, 32'h0, 0);
    checks++; if ({obs_stall != 0, obs_mis, obs_data} !== {2'b00, last_data}) begin
      errors++; $display("FAIL nonmem: got stall=%0d mis=%b data=%h expected stall=0 mis=0 data=%h", obs_stall, obs_mis, obs_data, last_data);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    sb.push_back(mk_exp(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, TMO - 1, 0, 1'b1));
    do_op(1, 0, 3'b010, 32'h300, 32'h0, 0, 0, 32'h0, 1);
    e = sb.pop_front();
    checks++; if (obs_reqs !== TMO) begin errors++; $display("FAIL tmo_req_cycles: got %0d expected %0d", obs_reqs, TMO); end
    checks++; if ({obs_err, obs_err_early, obs_data} !== {e.err, 1'b0, e.data}) begin
      errors++; $display("FAIL tmo_done: got err=%b early=%b data=%h expected err=1 early=0 data=0", obs_err, obs_err_early, obs_data);
    end
    checks++; if (obs_stall !== TMO + 1) begin errors++; $display("FAIL tmo_stall: got %0d expected %0d", obs_stall, TMO + 1); end
    go_idle();
    checks++; if ({bus_err_o, stall_o, dmem_req_o} !== 3'b000) begin errors++; $display("FAIL tmo_idle: got %b expected 000", {bus_err_o, stall_o, dmem_req_o}); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    mem_rd_i = 1; funct3_i = 3'b010; alu_out_i = 32'h400;
    @(posedge clk); #1;
    dmem_gnt_i = 1;
    @(posedge clk); #1;
    dmem_gnt_i = 0; reset = 1;
    @(negedge clk);
    checks++; if ({stall_o, dmem_req_o} !== 2'b10) begin errors++; $display("FAIL wait_r_entry: got %b expected 10", {stall_o, dmem_req_o}); end
    @(posedge clk); #1;
    reset = 0; mem_rd_i = 0; alu_out_i = 0;
    @(negedge clk);
    checks++; if ({stall_o, dmem_req_o, misalign_o, bus_err_o} !== 4'b0000) begin errors++; $display("FAIL rst_mid_idle: got %b expected 0000", {stall_o, dmem_req_o, misalign_o, bus_err_o}); end
    @(posedge clk); #1;
    dmem_rvalid_i = 1; dmem_rdata_i = 32'h12345678;
    @(posedge clk); #1;
    dmem_rvalid_i = 0;
    @(negedge clk);
    checks++; if ({mem_data_o, stall_o} !== 33'd0) begin errors++; $display("FAIL late_rvalid: got data=%h stall=%b expected 0", mem_data_o, stall_o); end
    last_data = 32'h0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] f3tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    exp_t e;
    for (int n = 0; n < 24; n++) begin
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] a, rs2, rd_word, exp_d;
      int          g, r;
      wr = 1'($urandom_range(0, 1));
      f3 = f3tab[$urandom_range(0, 4)];
      if (wr) f3[2] = 1'b0;
      a  = $urandom & 32'hFFFF_FFFC;
      if (f3[1:0] == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
      if (f3[1:0] == 2'b01) a[1]   = 1'($urandom_range(0, 1));
      rs2 = $urandom; rd_word = $urandom;
      g = $urandom_range(0, 3); r = $urandom_range(1, 3);
      exp_d = wr ? last_data : m_ext(f3, a, rd_word);
      sb.push_back(mk_exp(wr, f3, a, rs2, exp_d, g, r, 1'b0));
      do_op(~wr, wr, f3, a, rs2, g, r, rd_word, 0);
      e = sb.pop_front();
      last_data = exp_d;
      checks++;
      if (obs_hung || obs_unstable || obs_err || obs_stall !== e.stall || obs_reqs !== e.reqs ||
          {obs_data, obs_addr, obs_be, obs_wdata, obs_we} !== {e.data, e.addr, e.be, e.wdata, e.we}) begin
        errors++;
        $display("FAIL b2b[%0d]: got data=%h addr=%h be=%b wd=%h we=%b stall=%0d reqs=%0d uns=%b err=%b expected data=%h addr=%h be=%b wd=%h we=%b stall=%0d reqs=%0d",
                 n, obs_data, obs_addr, obs_be, obs_wdata, obs_we, obs_stall, obs_reqs, obs_unstable, obs_err,
                 e.data, e.addr, e.be, e.wdata, e.we, e.stall, e.reqs);
      end
    end
    go_idle();
  endtask

  initial begin
    reset = 1; mem_rd_i = 0; mem_wr_i = 0; kill_i = 0; funct3_i = 0;
    alu_out_i = 0; rs2_data_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    last_data = 0;
    repeat (2) @(posedge clk);
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    go_idle();
    test_misalign();
    test_kill_nonmem();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
